// File: rtl/id_ex_stage_pkg.sv
// Shared constants for the ID/EX pipeline register.
// Control bundle bit positions, widths, bubble value.
package id_ex_stage_pkg;

  localparam int DW = 32;
  localparam int CW = 8;

  localparam int CTRL_REGDST   = 7;
  localparam int CTRL_ALUOP_HI = 6;
  localparam int CTRL_ALUOP_LO = 5;
  localparam int CTRL_ALUSRC   = 4;
  localparam int CTRL_MEMREAD  = 3;
  localparam int CTRL_MEMWRITE = 2;
  localparam int CTRL_REGWRITE = 1;
  localparam int CTRL_MEMTOREG = 0;

  localparam logic [CW-1:0] BUBBLE_CTRL = 8'h00;

endpackage

// File: rtl/id_ex_stage_load_use_detect.sv
// Load-use hazard compare between the load in EX and the
// instruction in ID. Ports: EX valid/MemRead/rt, ID rs/rt, lu.
module load_use_detect (
  input  logic       ex_valid,
  input  logic       ex_memread,
  input  logic [4:0] ex_rt,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  output logic       lu
);

  // $0 is hardwired to zero, so a load into it never conflicts.
  assign lu = ex_valid & ex_memread & (ex_rt != 5'd0) &
              ((ex_rt == id_rs) | (ex_rt == id_rt));

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX register with load-use bubble, flush and EX hold.
// Ports: id_* in, ex_* out, flush/ex_hold, stall outs, bubble_cnt.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int DW  = 32,
  parameter int CW  = 8,
  parameter int BCW = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [CW-1:0]  id_ctrl,
  input  logic           id_branch,
  input  logic           id_jump,
  input  logic [DW-1:0]  id_pc4,
  input  logic [DW-1:0]  id_rd1,
  input  logic [DW-1:0]  id_rd2,
  input  logic [DW-1:0]  id_imm,
  input  logic [4:0]     id_rs,
  input  logic [4:0]     id_rt,
  input  logic [4:0]     id_rd,
  input  logic [5:0]     id_funct,
  input  logic           flush,
  input  logic           ex_hold,
  output logic [CW-1:0]  ex_ctrl,
  output logic           ex_branch,
  output logic           ex_jump,
  output logic [DW-1:0]  ex_pc4,
  output logic [DW-1:0]  ex_rd1,
  output logic [DW-1:0]  ex_rd2,
  output logic [DW-1:0]  ex_imm,
  output logic [4:0]     ex_rs,
  output logic [4:0]     ex_rt,
  output logic [4:0]     ex_rd,
  output logic [5:0]     ex_funct,
  output logic           ex_valid,
  output logic           pc_write,
  output logic           if_id_write,
  output logic [BCW-1:0] bubble_cnt
);

  logic lu;
  logic bubble;
  logic stall;

  load_use_detect u_lu (
    .ex_valid   (ex_valid),
    .ex_memread (ex_ctrl[CTRL_MEMREAD]),
    .ex_rt      (ex_rt),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .lu         (lu)
  );

  assign bubble = flush | lu;

  // A flushed instruction is discarded, so it cannot stall.
  assign stall       = ex_hold | (lu & ~flush);
  assign pc_write    = ~stall;
  assign if_id_write = ~stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_ctrl    <= '0;
      ex_branch  <= 1'b0;
      ex_jump    <= 1'b0;
      ex_pc4     <= '0;
      ex_rd1     <= '0;
      ex_rd2     <= '0;
      ex_imm     <= '0;
      ex_rs      <= '0;
      ex_rt      <= '0;
      ex_rd      <= '0;
      ex_funct   <= '0;
      ex_valid   <= 1'b0;
      bubble_cnt <= '0;
    end else if (!ex_hold) begin
      if (bubble) begin
        ex_ctrl   <= CW'(BUBBLE_CTRL);
        ex_branch <= 1'b0;
        ex_jump   <= 1'b0;
        ex_pc4    <= '0;
        ex_rd1    <= '0;
        ex_rd2    <= '0;
        ex_imm    <= '0;
        ex_rs     <= '0;
        ex_rt     <= '0;
        ex_rd     <= '0;
        ex_funct  <= '0;
        ex_valid  <= 1'b0;
        if (bubble_cnt != '1)
          bubble_cnt <= bubble_cnt + BCW'(1);
      end else begin
        ex_ctrl   <= id_ctrl;
        ex_branch <= id_branch;
        ex_jump   <= id_jump;
        ex_pc4    <= id_pc4;
        ex_rd1    <= id_rd1;
        ex_rd2    <= id_rd2;
        ex_imm    <= id_imm;
        ex_rs     <= id_rs;
        ex_rt     <= id_rt;
        ex_rd     <= id_rd;
        ex_funct  <= id_funct;
        ex_valid  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized and directed bench for id_ex_stage.
// Reference: an expected EX-slot record updated per edge.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  id_ctrl;
  logic        id_branch, id_jump;
  logic [31:0] id_pc4, id_rd1, id_rd2, id_imm;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [5:0]  id_funct;
  logic        flush, ex_hold;
  logic [7:0]  ex_ctrl;
  logic        ex_branch, ex_jump;
  logic [31:0] ex_pc4, ex_rd1, ex_rd2, ex_imm;
  logic [4:0]  ex_rs, ex_rt, ex_rd;
  logic [5:0]  ex_funct;
  logic        ex_valid, pc_write, if_id_write;
  logic [15:0] bubble_cnt;

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst(rst),
    .id_ctrl(id_ctrl), .id_branch(id_branch),
    .id_jump(id_jump), .id_pc4(id_pc4),
    .id_rd1(id_rd1), .id_rd2(id_rd2),
    .id_imm(id_imm), .id_rs(id_rs),
    .id_rt(id_rt), .id_rd(id_rd),
    .id_funct(id_funct), .flush(flush),
    .ex_hold(ex_hold), .ex_ctrl(ex_ctrl),
    .ex_branch(ex_branch), .ex_jump(ex_jump),
    .ex_pc4(ex_pc4), .ex_rd1(ex_rd1),
    .ex_rd2(ex_rd2), .ex_imm(ex_imm),
    .ex_rs(ex_rs), .ex_rt(ex_rt),
    .ex_rd(ex_rd), .ex_funct(ex_funct),
    .ex_valid(ex_valid), .pc_write(pc_write),
    .if_id_write(if_id_write),
    .bubble_cnt(bubble_cnt)
  );

  typedef struct packed {
    logic [7:0]  ctrl;
    logic        br;
    logic        jp;
    logic [31:0] pc4;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [5:0]  funct;
    logic        valid;
  } slot_t;

  slot_t       m;
  int unsigned mcnt;

  task automatic chk(input string tag,
                     input logic [191:0] got,
                     input logic [191:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit m_hazard();
    if (!m.valid || !m.ctrl[3] || m.rt == 0) return 0;
    return (m.rt == id_rs) || (m.rt == id_rt);
  endfunction

  function automatic bit m_stall();
    return ex_hold || (m_hazard() && !flush);
  endfunction

  task automatic m_edge();
    if (ex_hold) return;
    if (flush || m_hazard()) begin
      m = '0;
      if (mcnt < 65535) mcnt++;
    end else begin
      m = '{id_ctrl, id_branch, id_jump, id_pc4,
            id_rd1, id_rd2, id_imm, id_rs, id_rt,
            id_rd, id_funct, 1'b1};
    end
  endtask

  function automatic slot_t dut_slot();
    return '{ex_ctrl, ex_branch, ex_jump, ex_pc4,
             ex_rd1, ex_rd2, ex_imm, ex_rs, ex_rt,
             ex_rd, ex_funct, ex_valid};
  endfunction

  task automatic check_outs(input string tag);
    chk({tag, ".slot"}, 192'(dut_slot()), 192'(m));
    chk({tag, ".cnt"}, 192'(bubble_cnt), 192'(mcnt));
  endtask

  // One clock: stall outputs before the edge, state after.
  task automatic cyc(input string tag);
    #1;
    chk({tag, ".pcw"}, 192'(pc_write), 192'(!m_stall()));
    chk({tag, ".ifw"}, 192'(if_id_write), 192'(!m_stall()));
    @(posedge clk);
    m_edge();
    #1;
    check_outs(tag);
  endtask

  task automatic set_id(input logic [7:0] c,
                        input logic [4:0] rs,
                        input logic [4:0] rt,
                        input logic [4:0] rd);
    id_ctrl = c;
    id_rs = rs;
    id_rt = rt;
    id_rd = rd;
    id_pc4 = $urandom;
    id_imm = $urandom;
    id_rd1 = $urandom;
    id_rd2 = $urandom;
    id_funct = 6'($urandom);
    id_branch = 1'b0;
    id_jump = 1'b0;
  endtask

  localparam logic [7:0] RTYPE = 8'b11000010;
  localparam logic [7:0] LW    = 8'b00011011;

  initial begin
    logic [15:0] c0;
    rst = 1'b1;
    flush = 1'b0;
    ex_hold = 1'b0;
    set_id(RTYPE, 5'd1, 5'd2, 5'd3);
    m = '0;
    mcnt = 0;
    #12;
    check_outs("reset");
    @(negedge clk);
    rst = 1'b0;

    // plain R-type flow
    set_id(RTYPE, 5'd1, 5'd2, 5'd8);
    id_rd1 = 32'h5;
    id_rd2 = 32'h7;
    cyc("rtype");
    chk("rtype.ctrl", 192'(ex_ctrl), 192'(RTYPE));
    chk("rtype.rd1", 192'(ex_rd1), 192'(32'h5));
    chk("rtype.rd2", 192'(ex_rd2), 192'(32'h7));
    chk("rtype.rd", 192'(ex_rd), 192'(5'd8));
    chk("rtype.vld", 192'(ex_valid), 192'(1'b1));

    // async reset mid-cycle
    #2;
    rst = 1'b1;
    m = '0;
    mcnt = 0;
    #1;
    check_outs("midrst");
    chk("midrst.pcw", 192'(pc_write), 192'(1'b1));
    rst = 1'b0;
    @(negedge clk);

    // load-use: LW rt=9, then ADDU rs=9
    set_id(LW, 5'd1, 5'd9, 5'd0);
    cyc("lw");
    set_id(RTYPE, 5'd9, 5'd4, 5'd10);
    #1;
    chk("lu.pcw0", 192'(pc_write), 192'(1'b0));
    chk("lu.ifw0", 192'(if_id_write), 192'(1'b0));
    cyc("lu.bub");
    chk("lu.ctrl", 192'(ex_ctrl), 192'(8'h00));
    chk("lu.vld", 192'(ex_valid), 192'(1'b0));
    chk("lu.cnt1", 192'(bubble_cnt), 192'(16'd1));
    chk("lu.pcw1", 192'(pc_write), 192'(1'b1));
    cyc("lu.addu");
    chk("lu.addurs", 192'(ex_rs), 192'(5'd9));
    chk("lu.adduv", 192'(ex_valid), 192'(1'b1));

    // $0 load never stalls
    set_id(LW, 5'd2, 5'd0, 5'd0);
    cyc("z.lw");
    c0 = bubble_cnt;
    set_id(RTYPE, 5'd0, 5'd0, 5'd11);
    #1;
    chk("z.pcw", 192'(pc_write), 192'(1'b1));
    cyc("z.use");
    chk("z.cnt", 192'(bubble_cnt), 192'(c0));

    // flush wins over load-use, counted once
    set_id(LW, 5'd2, 5'd9, 5'd0);
    cyc("f.lw");
    c0 = bubble_cnt;
    set_id(RTYPE, 5'd9, 5'd9, 5'd12);
    flush = 1'b1;
    #1;
    chk("f.pcw", 192'(pc_write), 192'(1'b1));
    cyc("f.bub");
    flush = 1'b0;
    chk("f.cnt", 192'(bubble_cnt), 192'(c0 + 16'd1));
    chk("f.vld", 192'(ex_valid), 192'(1'b0));

    // hold freezes the stage, then flush applies
    set_id(RTYPE, 5'd3, 5'd4, 5'd13);
    cyc("h.load");
    c0 = bubble_cnt;
    ex_hold = 1'b1;
    flush = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_id(LW, 5'(i), 5'(i + 5), 5'd14);
      #1;
      chk("h.pcw", 192'(pc_write), 192'(1'b0));
      cyc("h.frz");
      chk("h.rd", 192'(ex_rd), 192'(5'd13));
      chk("h.cnt", 192'(bubble_cnt), 192'(c0));
    end
    ex_hold = 1'b0;
    cyc("h.rel");
    flush = 1'b0;
    chk("h.relv", 192'(ex_valid), 192'(1'b0));
    chk("h.relc", 192'(bubble_cnt), 192'(c0 + 16'd1));

    // randomized traffic against the reference
    for (int i = 0; i < 400; i++) begin
      set_id(8'($urandom), 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)), 5'($urandom));
      if ($urandom_range(0, 3) == 0) id_ctrl[3] = 1'b1;
      id_branch = 1'($urandom);
      id_jump = 1'($urandom);
      if (ex_hold && flush)
        flush = 1'b1;
      else
        flush = ($urandom_range(0, 7) == 0);
      ex_hold = ($urandom_range(0, 7) == 0);
      cyc("rnd");
      if (ex_valid == 1'b0) begin
        chk("rnd.bw", 192'({ex_ctrl[2], ex_ctrl[1]}),
            192'(2'b00));
      end
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register for the 5-stage MIPS pipeline. Sits directly downstream of the control unit and register file.
- Latches the decode-stage 8-bit control bundle, Branch/Jump, operands, immediate and register specifiers, and presents them to EX one cycle later.
- Contains load-use hazard detection: inserts a bubble and stalls PC and IF/ID.
- Honours a flush from branch/jump resolution and a hold from a multi-cycle EX op (MADDU).

Parameters:
- DW, 32, datapath width (operands, PC+4, immediate).
- CW, 8, control bundle width.
- BCW, 16, bubble counter width.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- id_ctrl  in  CW  {RegDst, ALUOp[1:0], ALUSrc, MemRead, MemWrite, RegWrite, MemtoReg}, bit 7 = RegDst
- id_branch  in  1  Branch from control unit
- id_jump  in  1  Jump from control unit
- id_pc4  in  DW  PC+4 of the decode instruction
- id_rd1  in  DW  register file port 1 data (rs)
- id_rd2  in  DW  register file port 2 data (rt)
- id_imm  in  DW  extended immediate
- id_rs  in  5  rs field
- id_rt  in  5  rt field
- id_rd  in  5  rd field
- id_funct  in  6  funct field
- flush  in  1  kill the decode instruction (taken branch/jump)
- ex_hold  in  1  EX busy; freeze the stage
- ex_ctrl  out  CW  registered control bundle
- ex_branch  out  1  registered Branch
- ex_jump  out  1  registered Jump
- ex_pc4, ex_rd1, ex_rd2, ex_imm  out  DW  registered data
- ex_rs, ex_rt, ex_rd  out  5  registered specifiers
- ex_funct  out  6  registered funct
- ex_valid  out  1  EX slot holds a real instruction
- pc_write  out  1  PC may advance (combinational)
- if_id_write  out  1  IF/ID may load (combinational)
- bubble_cnt  out  BCW  saturating count of inserted bubbles

Behaviour:
- Reset (async, rst=1): all ex_* outputs, ex_valid and bubble_cnt go to 0 immediately. Reset mid-stall clears the stall at once, because the hazard compare uses the cleared registers.
- Load-use detection (combinational): lu = ex_valid & ex_ctrl[3] & (ex_rt != 0) & ((ex_rt == id_rs) | (ex_rt == id_rt)).
- Per-edge action, in priority order:
  1. ex_hold=1: all registers keep their value; flush and lu are ignored that cycle.
  2. flush=1: load a bubble (ex_valid=0, ex_ctrl=0, ex_branch=0, ex_jump=0; data fields don't-care, implemented as 0). The flush source holds flush until a non-hold edge.
  3. lu=1: load a bubble.
  4. Otherwise load all id_* inputs with ex_valid=1.
- Stall outputs: pc_write = if_id_write = ~(ex_hold | (lu & ~flush)).
  - Flush suppresses the stall, since the wrong-path instruction is discarded.
- Latency: one cycle from id_* to ex_*. A load-use stall lasts exactly one cycle, because the bubble clears ex_ctrl[3].
- bubble_cnt: increments on every edge that loads a bubble via rule 2 or 3; saturates at all-ones; not incremented on hold.
- Control bits the control unit drives as x (RegDst/MemtoReg for SW/BEQ/J, ALUOp bit for SW) are registered as presented. MemRead, MemWrite, RegWrite, Branch and Jump are always defined for implemented opcodes.
- Defined values on bubble: a bubble must never carry RegWrite=1 or MemWrite=1.

Decomposition:
- Shared package holds:
  - CTRL_* bit-index constants for the 8-bit bundle (REGDST=7, ALUOP_HI=6, ALUOP_LO=5, ALUSRC=4, MEMREAD=3, MEMWRITE=2, REGWRITE=1, MEMTOREG=0).
  - CW/DW widths.
  - A BUBBLE_CTRL constant of 8'h00.
- One natural sub-module: load_use_detect, the combinational lu equation. Everything else stays in id_ex_stage.

Test Plan:
- Reset during operation: rst pulse mid-cycle with ex_ctrl=8'b11000010 -> all ex_* and bubble_cnt read 0 before the next edge; pc_write=1.
- Plain flow: R-type (id_ctrl=8'b11000010, id_rd1=32'h5, id_rd2=32'h7, id_rd=5'd8) -> one cycle later ex_ctrl=8'b11000010, ex_rd1=5, ex_rd2=7, ex_rd=8, ex_valid=1.
- Load-use: LW (id_ctrl=8'b00011011, id_rt=9), then ADDU with id_rs=9 -> pc_write=0 and if_id_write=0 for exactly one cycle; next ex_ctrl=0, ex_valid=0; bubble_cnt=1; the ADDU enters EX on the following edge.
- $0 load-use: LW with rt=0, then a consumer using rs=0 -> no stall; bubble_cnt unchanged.
- Flush vs load-use: flush=1 while lu=1 -> bubble loaded, pc_write=1, bubble_cnt increments by 1 only.
- Hold: ex_hold=1 for 3 cycles with changing id_* and flush=1 -> ex_* frozen; pc_write=0; bubble_cnt unchanged. On release, flush takes effect and yields a bubble.
